// File: rtl/ctrl_somador_serial.sv
// ctrl_somador_serial
// Nibble-serial add/subtract sequencer that drives one shared external 4-bit
// ripple-carry adder. It feeds one nibble per clock, LSB first, and chains
// the carry through a register to produce NIBBLES*4-bit sums/differences.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start, sub        - request and mode (0 = a+b, 1 = a-b), sampled in IDLE/DONE
//   op_a, op_b        - W-bit operands, latched on acceptance
//   busy              - high while the operation is running
//   done              - one-cycle pulse, result/carry_out/overflow valid
//   result            - registered W-bit sum/difference (wraps modulo 2^W)
//   carry_out         - final adder carry (for sub: 1 = no borrow)
//   overflow          - two's-complement overflow of the W-bit operation
//   add_a, add_b, add_cin - to the external adder (zero outside RUN)
//   add_s, add_cout   - from the external adder (combinational)
module ctrl_somador_serial #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
);

    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] IDX_LAST = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   a_r;
    logic [W-1:0]   a_s;
    logic [W-1:0]   b_r;
    logic [W-1:0]   b_s;
    logic           cy_r;
    logic           cy_s;
    logic [2:0]     idx_r;
    logic [2:0]     idx_s;
    logic           busy_s;
    logic           done_s;
    logic [W-1:0]   result_s;
    logic           carry_out_s;
    logic           overflow_s;

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        cy_s        = cy_r;
        idx_s       = idx_r;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        result_s    = result;
        carry_out_s = carry_out;
        overflow_s  = overflow;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b here, seed the carry with 1.
                    a_s     = op_a;
                    b_s     = sub ? ~op_b : op_b;
                    cy_s    = sub;
                    idx_s   = 3'd0;
                    state_s = ST_RUN;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_s[4*idx_r +: 4] = add_s;
                cy_s                   = add_cout;
                if (idx_r == IDX_LAST) begin
                    carry_out_s = add_cout;
                    // Sign check uses the stored (possibly inverted) b operand.
                    overflow_s  = (a_r[W-1] == b_r[W-1]) && (add_s[3] != a_r[W-1]);
                    idx_s       = 3'd0;
                    state_s     = ST_DONE;
                    done_s      = 1'b1;
                end else begin
                    idx_s  = idx_r + 3'd1;
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            cy_r      <= 1'b0;
            idx_r     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            b_r       <= b_s;
            cy_r      <= cy_s;
            idx_r     <= idx_s;
            busy      <= busy_s;
            done      <= done_s;
            result    <= result_s;
            carry_out <= carry_out_s;
            overflow  <= overflow_s;
        end
    end

    // Adder operand decode from the latched operands; idle adder sees zeros.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state_r == ST_RUN) begin
            add_a   = a_r[4*idx_r +: 4];
            add_b   = b_r[4*idx_r +: 4];
            add_cin = cy_r;
        end else begin
            add_a   = 4'd0;
            add_b   = 4'd0;
            add_cin = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_somador_serial.sv
// Testbench for ctrl_somador_serial: one 8-bit and one 16-bit instance, each
// paired with a behavioural 4-bit adder, driven with directed vectors.
module tb_ctrl_somador_serial;

    logic        clk_s;
    logic        rst_s;

    logic        start2_s, sub2_s, busy2_s, done2_s, carry2_s, ovf2_s;
    logic [7:0]  op_a2_s, op_b2_s, result2_s;
    logic [3:0]  add_a2_s, add_b2_s, add_s2_s;
    logic        add_cin2_s, add_cout2_s;

    logic        start4_s, sub4_s, busy4_s, done4_s, carry4_s, ovf4_s;
    logic [15:0] op_a4_s, op_b4_s, result4_s;
    logic [3:0]  add_a4_s, add_b4_s, add_s4_s;
    logic        add_cin4_s, add_cout4_s;

    int check_cnt;
    int error_cnt;

    // External 4-bit ripple-carry adders.
    assign {add_cout2_s, add_s2_s} = 5'(add_a2_s) + 5'(add_b2_s) + 5'(add_cin2_s);
    assign {add_cout4_s, add_s4_s} = 5'(add_a4_s) + 5'(add_b4_s) + 5'(add_cin4_s);

    ctrl_somador_serial #(.NIBBLES(2)) dut2 (
        .clk(clk_s), .rst(rst_s), .start(start2_s), .sub(sub2_s),
        .op_a(op_a2_s), .op_b(op_b2_s), .busy(busy2_s), .done(done2_s),
        .result(result2_s), .carry_out(carry2_s), .overflow(ovf2_s),
        .add_a(add_a2_s), .add_b(add_b2_s), .add_cin(add_cin2_s),
        .add_s(add_s2_s), .add_cout(add_cout2_s)
    );

    ctrl_somador_serial #(.NIBBLES(4)) dut4 (
        .clk(clk_s), .rst(rst_s), .start(start4_s), .sub(sub4_s),
        .op_a(op_a4_s), .op_b(op_b4_s), .busy(busy4_s), .done(done4_s),
        .result(result4_s), .carry_out(carry4_s), .overflow(ovf4_s),
        .add_a(add_a4_s), .add_b(add_b4_s), .add_cin(add_cin4_s),
        .add_s(add_s4_s), .add_cout(add_cout4_s)
    );

    // Free-running clock.
    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Present a request to the 8-bit instance and let it be accepted.
    task automatic launch2(input logic [7:0] a, input logic [7:0] b, input logic s);
        op_a2_s  = a;
        op_b2_s  = b;
        sub2_s   = s;
        start2_s = 1'b1;
        tick();
        start2_s = 1'b0;
        check_val("launch_busy", 32'(busy2_s), 32'd1);
        check_val("launch_done", 32'(done2_s), 32'd0);
    endtask

    // Run the remaining cycles of an 8-bit operation and check the outcome.
    task automatic finish2(input string tag, input logic [7:0] res, input logic cy, input logic ov);
        tick();
        check_val({tag, "_mid_busy"}, 32'(busy2_s), 32'd1);
        check_val({tag, "_mid_done"}, 32'(done2_s), 32'd0);
        tick();
        check_val({tag, "_done"}, 32'(done2_s), 32'd1);
        check_val({tag, "_busy"}, 32'(busy2_s), 32'd0);
        check_val({tag, "_result"}, 32'(result2_s), 32'(res));
        check_val({tag, "_carry"}, 32'(carry2_s), 32'(cy));
        check_val({tag, "_ovf"}, 32'(ovf2_s), 32'(ov));
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        rst_s = 1'b1;
        start2_s = 1'b0; sub2_s = 1'b0; op_a2_s = 8'h00; op_b2_s = 8'h00;
        start4_s = 1'b0; sub4_s = 1'b0; op_a4_s = 16'h0000; op_b4_s = 16'h0000;
        tick();
        tick();
        rst_s = 1'b0;
        check_val("rst_busy", 32'(busy2_s), 32'd0);
        check_val("rst_done", 32'(done2_s), 32'd0);
        check_val("rst_result", 32'(result2_s), 32'd0);
        check_val("rst_add_a", 32'(add_a2_s), 32'd0);
        check_val("rst_result4", 32'(result4_s), 32'd0);

        // 0x3C + 0x45 = 0x81, signed overflow.
        launch2(8'h3C, 8'h45, 1'b0);
        check_val("c1_add_a", 32'(add_a2_s), 32'hC);
        check_val("c1_add_b", 32'(add_b2_s), 32'h5);
        check_val("c1_add_cin", 32'(add_cin2_s), 32'd0);
        finish2("add", 8'h81, 1'b0, 1'b1);

        // Back-to-back subtractions issued from the DONE cycle.
        launch2(8'h10, 8'h01, 1'b1);
        finish2("sub1", 8'h0F, 1'b1, 1'b0);
        launch2(8'h00, 8'h01, 1'b1);
        finish2("sub2", 8'hFF, 1'b0, 1'b0);
        launch2(8'h80, 8'h01, 1'b1);
        finish2("sub3", 8'h7F, 1'b1, 1'b1);

        // New request during RUN must be ignored: 0x7F + 0x01 completes.
        launch2(8'h7F, 8'h01, 1'b0);
        op_a2_s = 8'hFF; op_b2_s = 8'hFF; sub2_s = 1'b1; start2_s = 1'b1;
        tick();
        start2_s = 1'b0;
        check_val("ign_busy", 32'(busy2_s), 32'd1);
        tick();
        check_val("ign_done", 32'(done2_s), 32'd1);
        check_val("ign_result", 32'(result2_s), 32'h80);
        check_val("ign_carry", 32'(carry2_s), 32'd0);
        check_val("ign_ovf", 32'(ovf2_s), 32'd1);

        // Idle hold: results persist, adder inputs parked at zero.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_done", 32'(done2_s), 32'd0);
            check_val("hold_busy", 32'(busy2_s), 32'd0);
            check_val("hold_result", 32'(result2_s), 32'h80);
            check_val("hold_carry", 32'(carry2_s), 32'd0);
            check_val("hold_ovf", 32'(ovf2_s), 32'd1);
            check_val("hold_adder", 32'({add_a2_s, add_b2_s, add_cin2_s}), 32'd0);
        end

        // Reset in the second RUN cycle aborts the operation.
        launch2(8'h3C, 8'h45, 1'b0);
        tick();
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        check_val("abort_busy", 32'(busy2_s), 32'd0);
        check_val("abort_done", 32'(done2_s), 32'd0);
        check_val("abort_result", 32'(result2_s), 32'd0);
        check_val("abort_flags", 32'({carry2_s, ovf2_s}), 32'd0);
        check_val("abort_adder", 32'({add_a2_s, add_b2_s, add_cin2_s}), 32'd0);
        tick();
        check_val("abort_nodone", 32'(done2_s), 32'd0);
        launch2(8'h25, 8'h13, 1'b1);
        finish2("post_rst", 8'h12, 1'b1, 1'b0);

        // 16-bit: 0xFFFF + 0x0001 ripples a carry through every nibble.
        op_a4_s = 16'hFFFF; op_b4_s = 16'h0001; sub4_s = 1'b0; start4_s = 1'b1;
        tick();
        start4_s = 1'b0;
        check_val("w4_c1_busy", 32'(busy4_s), 32'd1);
        check_val("w4_c1_add_a", 32'(add_a4_s), 32'hF);
        check_val("w4_c1_add_cin", 32'(add_cin4_s), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check_val("w4_chain_cin", 32'(add_cin4_s), 32'd1);
            check_val("w4_chain_busy", 32'(busy4_s), 32'd1);
            check_val("w4_chain_done", 32'(done4_s), 32'd0);
        end
        tick();
        check_val("w4_done", 32'(done4_s), 32'd1);
        check_val("w4_result", 32'(result4_s), 32'h0000);
        check_val("w4_carry", 32'(carry4_s), 32'd1);
        check_val("w4_ovf", 32'(ovf4_s), 32'd0);
        tick();
        check_val("w4_pulse", 32'(done4_s), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_somador_serial.md
Name: ctrl_somador_serial

Overview:
- Nibble-serial multi-word add/subtract sequencer for the irrigation controller's shared 4-bit ripple-carry adder.
- Instantiated beside one external 4-bit adder (a, b, cin -> s, cout). Drives the adder one nibble per clock, LSB first, and chains the carry through a register.
- Yields NIBBLES*4-bit sums and differences, e.g. water-volume accumulation and setpoint comparison, without widening the adder.

Parameters:
- NIBBLES, 2, operand width in nibbles (W = 4*NIBBLES); legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- op_a  input  W  operand A; sampled with start
- op_b  input  W  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- result  output  W  registered sum/difference
- carry_out  output  1  final adder carry (sub: 1 = no borrow, i.e. a>=b unsigned)
- overflow  output  1  two's-complement overflow of the W-bit operation
- add_a  output  4  to adder a
- add_b  output  4  to adder b
- add_cin  output  1  to adder cin
- add_s  input  4  from adder s (combinational)
- add_cout  input  1  from adder cout (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset (synchronous, rst=1 at an edge):
  - state <- IDLE; busy, done, result, carry_out, overflow <- 0; index and carry registers <- 0.
  - Reset mid-RUN aborts the operation: no done pulse, result stays 0.
- States: IDLE, RUN, DONE. State and all outputs are registered, except add_a/add_b/add_cin, which are decoded from registers.
- Start acceptance (IDLE or DONE, start=1 at an edge E0):
  - a_reg <- op_a; b_reg <- (sub ? ~op_b : op_b); cy <- sub; idx <- 0.
  - state <- RUN; done <- 0.
  - result, carry_out and overflow keep their previous values until overwritten.
- RUN:
  - add_a = a_reg[4*idx+3:4*idx]; add_b = b_reg nibble idx; add_cin = cy.
  - At each edge: result nibble idx <- add_s; cy <- add_cout; idx <- idx+1.
  - When idx == NIBBLES-1 at the edge: carry_out <- add_cout; overflow <- (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]); state <- DONE; done <- 1.
- Outside RUN: add_a = 0, add_b = 0, add_cin = 0.
- Timing: nibble k is captured at edge E(k+1); done is high in the cycle after edge E(NIBBLES). Latency is NIBBLES cycles from the accepting edge.
- DONE lasts exactly one cycle:
  - With start=0 -> IDLE, done <- 0.
  - With start=1 -> accepted as above (back-to-back); done <- 0 next cycle.
- start and operand changes while in RUN are ignored; operands are fully latched.
- result, carry_out and overflow hold their values in IDLE until the next completed operation.
- Width rules:
  - Result wraps modulo 2^W.
  - sub=1 computes a + ~b + 1.
  - overflow uses the post-inversion b sign.
- busy = (state == RUN); busy and done are never both high.

Test Plan:
- NIBBLES=2, sub=0, a=0x3C, b=0x45 -> done 2 cycles after the start edge; result=0x81, carry_out=0, overflow=1. Cycle 1 drives add_a=0xC, add_b=0x5, add_cin=0.
- NIBBLES=2, sub=1: a=0x10, b=0x01 -> 0x0F, carry_out=1, overflow=0. Then a=0x00, b=0x01 -> 0xFF, carry_out=0, overflow=0. Then a=0x80, b=0x01 -> 0x7F, overflow=1.
- NIBBLES=4, sub=0, a=0xFFFF, b=0x0001 -> result=0x0000, carry_out=1, overflow=0, done after 4 cycles; carry chain visible on add_cin=1 in cycles 2-4.
- Pulse start with new operands during RUN -> ignored; the original result completes with a single done pulse. start held in the DONE cycle -> second operation accepted with no IDLE gap.
- rst asserted for one cycle in the 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no done; a subsequent start completes normally.
- After done, hold start=0 for 10 cycles -> result, carry_out and overflow stable, busy=0, adder inputs 0.
